// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, register map and frame constants.
// UART_TX_PARITY_EN adds the PARITY state and the parity capability flag.
package uart_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam uart_state_t ST_PARITY = 3'd4;
  localparam logic        PARITY_CAP = 1'b1;
`else
  localparam logic        PARITY_CAP = 1'b0;
`endif

  // Registers are selected by a single address bit; these are its values.
  localparam int unsigned REG_SEL_BIT = 2;
  localparam logic        TX_DATA_OFS = 1'b0;
  localparam logic        STATUS_OFS  = 1'b1;

  localparam int unsigned STS_FULL       = 0;
  localparam int unsigned STS_EMPTY      = 1;
  localparam int unsigned STS_BUSY       = 2;
  localparam int unsigned STS_OVERFLOW   = 3;
  localparam int unsigned STS_COUNT_LSB  = 4;
  localparam int unsigned STS_COUNT_W    = 4;
  localparam int unsigned STS_PARITY_CAP = 8;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_IDX_W  = 3;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Memory-map slave bus carrying store data, slave-local address, write strobe and read data.
interface uart_tx_mmio_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] address;
  logic                  we;
  logic [DATA_WIDTH-1:0] rd;

  modport master (
    output wd,
    output address,
    output we,
    input  rd
  );

  modport slave (
    input  wd,
    input  address,
    input  we,
    output rd
  );

endinterface

// File: rtl/sync_fifo_param.sv
// Synchronous show-ahead FIFO with occupancy count; DEPTH must be a power of two >= 2.
module sync_fifo_param #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [LENGTH-1:0]        din,
  output logic [LENGTH-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [LENGTH-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: FIFO-buffered stores serialised as 8N1 frames on tx.
// Define UART_TX_PARITY_EN to append an even-parity bit and advertise it in STATUS[8].
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_mmio_if.slave bus,
  output logic          tx,
  output logic          irq_empty
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]     BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_t          state_q;
  uart_state_t          state_d;
  logic [CNT_W-1:0]     baud_q;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 ovf_q;
  logic                 tx_d;
  logic                 baud_done;

  logic                 sel_status;
  logic                 wr_data;
  logic                 wr_status;
  logic                 ovf_set;
  logic                 ovf_clr;
  logic [DATA_WIDTH-1:0] status;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [7:0]           fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OCC_W-1:0]     fifo_count;

  logic                 unused_bus_bits;

  sync_fifo_param #(
    .LENGTH (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register decode; a store into a full FIFO is dropped and flagged.
  assign sel_status = (bus.address[REG_SEL_BIT] == STATUS_OFS);
  assign wr_data    = bus.we && (bus.address[REG_SEL_BIT] == TX_DATA_OFS);
  assign wr_status  = bus.we && sel_status;
  assign fifo_push  = wr_data && !fifo_full;
  assign ovf_set    = wr_data && fifo_full;
  assign ovf_clr    = wr_status && bus.wd[STS_OVERFLOW];
  assign baud_done  = (baud_q == BAUD_LAST);

  assign unused_bus_bits = ^{bus.wd[DATA_WIDTH-1:8], bus.address[DATA_WIDTH-1:3],
                             bus.address[1:0]};

  always_comb begin
    status                                  = '0;
    status[STS_FULL]                        = fifo_full;
    status[STS_EMPTY]                       = fifo_empty;
    status[STS_BUSY]                        = (state_q != ST_IDLE);
    status[STS_OVERFLOW]                    = ovf_q;
    status[STS_COUNT_LSB +: STS_COUNT_W]    = STS_COUNT_W'(fifo_count);
    status[STS_PARITY_CAP]                  = PARITY_CAP;
    bus.rd = sel_status ? status : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, FIFO pop and the line level for the current state.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    tx_d     = STOP_BIT;
    case (state_q)
      ST_IDLE: begin
        tx_d = STOP_BIT;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx_d = START_BIT;
        if (baud_done) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shreg_q[bit_idx_q];
        if (baud_done && (bit_idx_q == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_d = ^shreg_q;
        if (baud_done) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx_d = STOP_BIT;
        // Chain straight into the next start bit when data is waiting.
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: baud timing, bit index, shift register, overflow and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      ovf_q     <= 1'b0;
      tx        <= STOP_BIT;
      irq_empty <= 1'b1;
    end else begin
      if ((state_d != state_q) || (state_q == ST_IDLE) || baud_done) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + CNT_W'(1);
      end

      if (state_q != ST_DATA) begin
        bit_idx_q <= '0;
      end else if (baud_done) begin
        bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
      end

      if (fifo_pop) begin
        shreg_q <= fifo_dout;
      end

      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end

      tx        <= tx_d;
      irq_empty <= fifo_empty && (state_q == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4; honours UART_TX_PARITY_EN.
module tb_uart_tx_mmio;

  localparam int unsigned DW    = 32;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned SLOTS = 11;
  localparam logic [31:0] CAP   = 32'h100;
`else
  localparam int unsigned SLOTS = 10;
  localparam logic [31:0] CAP   = 32'h000;
`endif
  localparam logic [31:0] ST_IDLE_EXP = 32'h02 | CAP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic irq_empty;
  int   tests = 0;
  int   fails = 0;

  uart_tx_mmio_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_mmio #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One store: sampled at the next edge, returns #1 after it.
  task automatic write(input logic [31:0] a, input logic [31:0] d);
    bus.we      = 1'b1;
    bus.address = a;
    bus.wd      = d;
    step(1);
    bus.we      = 1'b0;
    bus.address = 32'h0;
    bus.wd      = 32'h0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.rd, exp);
    bus.address = 32'h0;
  endtask

  // Checks tx every cycle of one frame; first sample is the edge after the FSM entered START.
  task automatic expect_frame(input logic [7:0] b, input int skip);
    logic [10:0] line;
    line      = '1;
    line[0]   = 1'b0;
    line[8:1] = b;
`ifdef UART_TX_PARITY_EN
    line[9]   = ^b;
`endif
    for (int i = skip; i < int'(SLOTS * CPB); i++) begin
      step(1);
      check($sformatf("frame_%02h_cyc%0d", b, i), 32'(tx), 32'(line[i / CPB]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.we      = 1'b0;
    bus.address = 32'h0;
    bus.wd      = 32'h0;
    rst         = 1'b1;
    step(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq_empty), 32'd1);
    read_check("rst_status", 32'h4, ST_IDLE_EXP);
    rst = 1'b0;

    // Idle line after reset
    step(20);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_irq", 32'(irq_empty), 32'd1);
    read_check("idle_status", 32'h4, ST_IDLE_EXP);
    read_check("txdata_read_zero", 32'h0, 32'h0);

    // Single frame 0xA5: tx low at N+2
    write(32'h0, 32'hA5);
    check("a5_tx_at_n", 32'(tx), 32'd1);
    step(1);
    check("a5_tx_at_n1", 32'(tx), 32'd1);
    check("a5_irq_at_n1", 32'(irq_empty), 32'd0);
    read_check("a5_status_busy", 32'h4, 32'h06 | CAP);
    expect_frame(8'hA5, 0);
    check("a5_irq_lag", 32'(irq_empty), 32'd0);
    step(1);
    check("a5_irq_back", 32'(irq_empty), 32'd1);
    read_check("a5_status_done", 32'h4, ST_IDLE_EXP);

    // Burst of five: first byte popped at N+1, so the fifth fits
    write(32'h0, 32'h11);
    write(32'h0, 32'h22);
    write(32'h0, 32'h3C);
    write(32'h0, 32'h80);
    write(32'h0, 32'hFF);
    read_check("burst_full", 32'h4, 32'h45 | CAP);
    write(32'h0, 32'h99);
    read_check("burst_overflow", 32'h4, 32'h4D | CAP);
    write(32'h4, 32'h0);
    read_check("ovf_kept_wd3_0", 32'h4, 32'h4D | CAP);
    write(32'h4, 32'h8);
    read_check("ovf_cleared", 32'h4, 32'h45 | CAP);
    expect_frame(8'h11, 6);
    expect_frame(8'h22, 0);
    expect_frame(8'h3C, 0);
    expect_frame(8'h80, 0);
    expect_frame(8'hFF, 0);
    step(1);
    check("burst_irq", 32'(irq_empty), 32'd1);
    read_check("burst_status_done", 32'h4, ST_IDLE_EXP);
    for (int k = 0; k < 12; k++) begin
      step(4);
      check($sformatf("dropped_byte_idle_%0d", k), 32'(tx), 32'd1);
    end

    // Reset during DATA with two bytes queued
    write(32'h0, 32'h00);
    write(32'h0, 32'hC3);
    write(32'h0, 32'h5A);
    step(8);
    check("pre_rst_data_low", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_irq", 32'(irq_empty), 32'd1);
    read_check("rst_async_status", 32'h4, ST_IDLE_EXP);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(4);
      check($sformatf("post_rst_idle_%0d", k), 32'(tx), 32'd1);
    end
    read_check("post_rst_status", 32'h4, ST_IDLE_EXP);

    // 0x07: parity bit 1 when enabled; frame length follows the build
    write(32'h0, 32'h07);
    step(1);
    read_check("p07_status_cap", 32'h4, 32'h06 | CAP);
    expect_frame(8'h07, 0);
    step(1);
    check("p07_tail_tx", 32'(tx), 32'd1);
    check("p07_irq", 32'(irq_empty), 32'd1);
    read_check("p07_status_done", 32'h4, ST_IDLE_EXP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
